// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the pixel row readout path.
// Capture and stream state encodings are exported so checkers can bind to them.
package pixel_readout_pkg;

   localparam int PIXEL_BITS = 8;
   localparam int DELAY_W    = 4;

   typedef enum logic [1:0] {
      WAIT_ROW = 2'd0,
      SETTLE   = 2'd1,
      HELD     = 2'd2
   } capture_state_t;

   typedef enum logic {
      EMPTY  = 1'b0,
      STREAM = 1'b1
   } stream_state_t;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_row_capture.sv
// Watches the one-hot READ bus, waits for it to settle and strobes a row capture.
// Multi-hot selects are flagged and never start or complete a capture.
module pixel_row_capture
   import pixel_readout_pkg::*;
#(
   parameter  int HEIGHT        = 2,
   parameter  int CAPTURE_DELAY = 2,
   localparam int ROW_W         = idx_w(HEIGHT)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [HEIGHT-1:0]    i_read,
   output logic                 o_capture,
   output logic [ROW_W-1:0]     o_row,
   output logic                 o_multi_hot,
   output capture_state_t       o_state
);

   localparam logic [DELAY_W-1:0] DELAY = DELAY_W'(CAPTURE_DELAY);

   capture_state_t       r_state;
   logic [HEIGHT-1:0]    r_latched;
   logic [ROW_W-1:0]     r_row;
   logic [DELAY_W-1:0]   r_cnt;

   logic [ROW_W-1:0]     w_enc;
   logic                 w_multi;
   logic                 w_sel;

   // Lowest set bit wins; multi-hot is detected separately below.
   always_comb begin
      w_enc = '0;
      for (int i = HEIGHT - 1; i >= 0; i--) begin
         if (i_read[i]) w_enc = ROW_W'(i);
      end
   end

   assign w_multi = (i_read & (i_read - HEIGHT'(1))) != '0;
   assign w_sel   = (i_read != '0) && !w_multi;

   assign o_capture   = (r_state == SETTLE) && (i_read == r_latched) && (r_cnt == DELAY);
   assign o_row       = r_row;
   assign o_multi_hot = w_multi;
   assign o_state     = r_state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= WAIT_ROW;
         r_latched <= '0;
         r_row     <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            WAIT_ROW: begin
               if (w_sel) begin
                  r_state   <= SETTLE;
                  r_latched <= i_read;
                  r_row     <= w_enc;
                  r_cnt     <= DELAY_W'(1);
               end
            end
            SETTLE: begin
               if (i_read != r_latched) r_state <= WAIT_ROW;
               else if (r_cnt == DELAY) r_state <= HELD;
               else r_cnt <= r_cnt + DELAY_W'(1);
            end
            HELD: begin
               // A different one-hot select starts settling on the same edge.
               if (i_read != r_latched) begin
                  if (w_sel) begin
                     r_state   <= SETTLE;
                     r_latched <= i_read;
                     r_row     <= w_enc;
                     r_cnt     <= DELAY_W'(1);
                  end else begin
                     r_state <= WAIT_ROW;
                  end
               end
            end
            default: r_state <= WAIT_ROW;
         endcase
      end
   end

endmodule

// File: rtl/pixel_row_readout.sv
// Buffers one captured pixel row and streams it out beat by beat over valid/ready.
// Handshake: a beat transfers when out_valid && out_ready at posedge; outputs hold while stalled.
module pixel_row_readout
   import pixel_readout_pkg::*;
#(
   parameter  int PIXEL_ARRAY_WIDTH  = 2,
   parameter  int PIXEL_ARRAY_HEIGHT = 2,
   parameter  int CAPTURE_DELAY      = 2,
   localparam int COL_W              = idx_w(PIXEL_ARRAY_WIDTH),
   localparam int ROW_W              = idx_w(PIXEL_ARRAY_HEIGHT)
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [PIXEL_ARRAY_HEIGHT-1:0]           read,
   input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] row_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [PIXEL_BITS-1:0]                   out_pixel,
   output logic [ROW_W-1:0]                        out_row,
   output logic [COL_W-1:0]                        out_col,
   output logic                                    out_sof,
   output logic                                    out_eof,
   output logic                                    overflow,
   output logic                                    select_err,
   output capture_state_t                          o_dbg_capture_state,
   output stream_state_t                           o_dbg_stream_state
);

   logic [PIXEL_BITS-1:0] r_buf [PIXEL_ARRAY_WIDTH];
   stream_state_t         r_stream;
   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;
   logic [PIXEL_BITS-1:0] r_pixel;
   logic                  r_overflow;
   logic                  r_select_err;

   logic                  w_capture;
   logic [ROW_W-1:0]      w_cap_row;
   logic                  w_multi;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_busy;
   logic                  w_row0;

   pixel_row_capture #(
      .HEIGHT        (PIXEL_ARRAY_HEIGHT),
      .CAPTURE_DELAY (CAPTURE_DELAY)
   ) u_capture (
      .clk         (clk),
      .reset       (reset),
      .i_read      (read),
      .o_capture   (w_capture),
      .o_row       (w_cap_row),
      .o_multi_hot (w_multi),
      .o_state     (o_dbg_capture_state)
   );

   assign w_accept = (r_stream == STREAM) && out_ready;
   assign w_last   = w_accept && (r_col == COL_W'(PIXEL_ARRAY_WIDTH - 1));
   // The buffer frees up on the edge that takes the last beat, so a capture there loads.
   assign w_busy   = (r_stream == STREAM) && !w_last;
   assign w_row0   = w_capture && (w_cap_row == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stream     <= EMPTY;
         r_col        <= '0;
         r_row        <= '0;
         r_pixel      <= '0;
         r_overflow   <= 1'b0;
         r_select_err <= 1'b0;
         for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) r_buf[c] <= '0;
      end else begin
         if (w_capture && !w_busy) begin
            for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++) r_buf[c] <= row_data[c*PIXEL_BITS +: PIXEL_BITS];
            r_pixel  <= row_data[PIXEL_BITS-1:0];
            r_col    <= '0;
            r_row    <= w_cap_row;
            r_stream <= STREAM;
         end else if (w_last) begin
            r_stream <= EMPTY;
            r_col    <= '0;
         end else if (w_accept) begin
            r_col   <= r_col + COL_W'(1);
            r_pixel <= r_buf[r_col + COL_W'(1)];
         end

         if (w_capture && w_busy) r_overflow <= 1'b1;
         else if (w_row0)         r_overflow <= 1'b0;

         if (w_multi)     r_select_err <= 1'b1;
         else if (w_row0) r_select_err <= 1'b0;
      end
   end

   assign out_valid          = (r_stream == STREAM);
   assign out_pixel          = r_pixel;
   assign out_row            = r_row;
   assign out_col            = r_col;
   assign out_sof            = out_valid && (r_row == '0) && (r_col == '0);
   assign out_eof            = out_valid && (r_row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1))
                                         && (r_col == COL_W'(PIXEL_ARRAY_WIDTH - 1));
   assign overflow           = r_overflow;
   assign select_err         = r_select_err;
   assign o_dbg_stream_state = r_stream;

endmodule

// File: tb/tb_pixel_row_readout.sv
// Bench for pixel_row_readout: directed scenarios plus random read/ready traffic,
// checked every cycle against a run-length based reference of the readout rules.
module tb_pixel_row_readout;
   import pixel_readout_pkg::*;

   localparam int W = 4;
   localparam int H = 4;
   localparam int D = 2;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            reset;
   logic            rst_req;
   logic [H-1:0]    read;
   logic [W*8-1:0]  row_data;
   logic            out_ready;
   logic            out_valid;
   logic [7:0]      out_pixel;
   logic [1:0]      out_row;
   logic [1:0]      out_col;
   logic            out_sof;
   logic            out_eof;
   logic            overflow;
   logic            select_err;
   capture_state_t  dbg_cap;
   stream_state_t   dbg_stream;

   always #5 clk = ~clk;

   pixel_row_readout #(
      .PIXEL_ARRAY_WIDTH  (W),
      .PIXEL_ARRAY_HEIGHT (H),
      .CAPTURE_DELAY      (D)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .read                (read),
      .row_data            (row_data),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_pixel           (out_pixel),
      .out_row             (out_row),
      .out_col             (out_col),
      .out_sof             (out_sof),
      .out_eof             (out_eof),
      .overflow            (overflow),
      .select_err          (select_err),
      .o_dbg_capture_state (dbg_cap),
      .o_dbg_stream_state  (dbg_stream)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   int eof_seen = 0;
   int eof_base;

   // reference: buffered row as (row, next column, data salt) plus sticky flags
   bit         m_valid;
   int         m_row;
   int         m_col;
   logic [7:0] m_salt;
   bit         m_ovf;
   bit         m_serr;
   // reference: current run of identical READ samples
   logic [H-1:0] s_val;
   int           s_len;
   int           s_skip;
   bit           s_oh;

   function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] s);
      return 8'(16 * r + c) ^ s;
   endfunction

   function automatic int lowest(input logic [H-1:0] v);
      int r = 0;
      for (int i = H - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_row = 0; m_col = 0; m_salt = '0; m_ovf = 0; m_serr = 0;
      s_val = '0; s_len = 0; s_skip = 0; s_oh = 0;
   endtask

   // Advance the reference across one posedge with the inputs just driven.
   // A one-hot value is captured once it has been seen on D+1 consecutive edges; a run that
   // directly follows an aborted settle loses its first edge (the abort edge).
   task automatic model_edge(input logic [H-1:0] rd, input logic rdy, input logic [7:0] salt);
      bit acc, last, cap, busy, multi, oh;
      int eff, crow;
      if (!reset) begin
         model_reset();
      end else begin
         multi = $countones(rd) > 1;
         oh    = $countones(rd) == 1;
         if (rd != s_val) begin
            eff    = s_len - s_skip;
            s_skip = (s_oh && eff >= 1 && eff < D + 1) ? 1 : 0;
            s_val  = rd;
            s_len  = 1;
            s_oh   = oh;
         end else begin
            s_len++;
         end
         cap  = oh && (s_len - s_skip == D + 1);
         crow = lowest(rd);
         acc  = m_valid && rdy;
         last = acc && (m_col == W - 1);
         busy = m_valid && !last;
         if (multi) m_serr = 1;
         else if (cap && crow == 0) m_serr = 0;
         if (cap && busy) m_ovf = 1;
         else if (cap && crow == 0) m_ovf = 0;
         if (cap && !busy) begin
            m_valid = 1; m_row = crow; m_col = 0; m_salt = salt;
         end else if (last) begin
            m_valid = 0;
         end else if (acc) begin
            m_col++;
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("out_valid", out_valid, m_valid);
      if (m_valid) begin
         check_eq("out_pixel", out_pixel, pix(m_row, m_col, m_salt));
         check_eq("out_row", out_row, m_row);
         check_eq("out_col", out_col, m_col);
      end
      check_eq("out_sof", out_sof, m_valid && m_row == 0 && m_col == 0);
      check_eq("out_eof", out_eof, m_valid && m_row == H - 1 && m_col == W - 1);
      check_eq("overflow", overflow, m_ovf);
      check_eq("select_err", select_err, m_serr);
      if (out_valid && out_eof) eof_seen++;
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [H-1:0] rd, input logic rdy, input logic [7:0] salt);
      @(negedge clk);
      check_outputs();
      reset     = rst_req;
      read      = rd;
      out_ready = rdy;
      for (int c = 0; c < W; c++) row_data[8*c +: 8] = pix(lowest(rd), c, salt);
      model_edge(rd, rdy, salt);
   endtask

   task automatic frame(input int hold, input logic rdy);
      for (int r = 0; r < H; r++) repeat (hold) step(H'(1) << r, rdy, 8'h00);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [H-1:0] v;
      logic [7:0]   salt;
      int           kind, len, a, b;

      reset = 1'b0; rst_req = 1'b0; read = '0; row_data = '0; out_ready = 1'b0;
      model_reset();
      repeat (3) step('0, 1'b0, 8'h00);
      rst_req = 1'b1;
      repeat (2) step('0, 1'b1, 8'h00);

      // single row 0
      repeat (5) step(4'b0001, 1'b1, 8'h00);
      repeat (6) step('0, 1'b1, 8'h00);

      // full frame, relaxed and back-to-back (last beat meets next capture)
      eof_base = eof_seen;
      frame(5, 1'b1);
      repeat (6) step('0, 1'b1, 8'h00);
      check_eq("eof_count_frame5", eof_seen - eof_base, 1);
      eof_base = eof_seen;
      frame(4, 1'b1);
      repeat (6) step('0, 1'b1, 8'h00);
      check_eq("eof_count_frame4", eof_seen - eof_base, 1);

      // sink stalled for a whole frame
      frame(5, 1'b0);
      check_eq("overflow_after_drop", overflow, 1);
      repeat (8) step('0, 1'b1, 8'h00);
      repeat (5) step(4'b0001, 1'b1, 8'h00);
      check_eq("overflow_cleared", overflow, 0);
      repeat (6) step('0, 1'b1, 8'h00);

      // too-short select
      step(4'b0001, 1'b1, 8'h00);
      repeat (5) step('0, 1'b1, 8'h00);

      // multi-hot select, then cleared by a row-0 capture
      repeat (4) step(4'b0011, 1'b1, 8'h00);
      repeat (2) step('0, 1'b1, 8'h00);
      check_eq("select_err_set", select_err, 1);
      repeat (5) step(4'b0001, 1'b1, 8'h00);
      repeat (6) step('0, 1'b1, 8'h00);

      // reset mid-row after two beats
      repeat (5) step(4'b0001, 1'b1, 8'h00);
      step('0, 1'b1, 8'h00);
      check_eq("col_before_reset", out_col, 2);
      #2;
      rst_req = 1'b0;
      reset   = 1'b0;
      model_reset();
      #1;
      check_eq("valid_async_reset", out_valid, 0);
      repeat (2) step('0, 1'b1, 8'h00);
      rst_req = 1'b1;
      repeat (6) step('0, 1'b1, 8'h00);

      // random read segments with random back-pressure
      for (int s = 0; s < 80; s++) begin
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, 7);
         salt = 8'($urandom_range(0, 255));
         if (kind < 2) begin
            v = '0;
         end else if (kind == 2) begin
            a = $urandom_range(0, H - 1);
            b = (a + 1 + $urandom_range(0, H - 2)) % H;
            v = (H'(1) << a) | (H'(1) << b);
         end else begin
            v = H'(1) << $urandom_range(0, H - 1);
         end
         for (int k = 0; k < len; k++) step(v, $urandom_range(0, 3) != 0, salt);
      end
      repeat (10) step('0, 1'b1, 8'h00);
      @(negedge clk);
      check_outputs();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
